conv_mac_accum: RTL and testbench

CONV_MAC_ACCUM -- requirements
Module: conv_mac_accum

---
 rtl/conv_mac_accum.sv | 137 +++++++++++++
 tb/tb_conv_mac_accum.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_accum.sv
// Convolution multiply-accumulate for one pixel channel: accumulates pix*coef over a
// window of taps, then rounds, shifts out the fixed-point fraction and clamps to pixel range.
module conv_mac_accum #(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned COEF_W = 16,
   parameter int unsigned FRAC   = 8,
   parameter int unsigned ACC_W  = 32
) (
   input  logic              Clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        tap_count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PIX_W-1:0]  pix,
   input  logic [COEF_W-1:0] coef,
   input  logic              pad,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  result,
   output logic [ACC_W-1:0]  acc_out
);

   localparam int unsigned PROD_W = PIX_W + 1 + COEF_W;
   localparam logic signed [ACC_W-1:0] ROUND_K = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] PIX_MAX = {{(ACC_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} stateT;

   stateT                    state, stateNext;
   logic [7:0]               tapsTarget;
   logic [7:0]               tapCnt;
   logic signed [ACC_W-1:0]  prodReg;
   logic                     prodValid;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  accNext;
   logic signed [PROD_W-1:0] prodFull;
   logic signed [ACC_W-1:0]  prodExt;
   logic signed [ACC_W-1:0]  roundSum;
   logic signed [ACC_W-1:0]  shifted;
   logic [PIX_W-1:0]         clamped;
   logic                     handshake;
   logic                     lastTap;
   logic [PIX_W-1:0]         resultReg;
   logic [ACC_W-1:0]         accOutReg;

   assign in_ready  = (state == ACCUM);
   assign busy      = (state != IDLE);
   assign out_valid = (state == OUT);
   assign result    = resultReg;
   assign acc_out   = accOutReg;

   assign handshake = in_valid && in_ready;
   assign lastTap   = (tapCnt == tapsTarget - 8'd1);

   // The pixel is zero-extended so it always multiplies as a non-negative value.
   assign prodFull = $signed({1'b0, pix}) * $signed(coef);
   assign prodExt  = {{(ACC_W-PROD_W){prodFull[PROD_W-1]}}, prodFull};

   assign accNext  = prodValid ? acc + prodReg : acc;
   assign roundSum = accNext + ROUND_K;
   assign shifted  = roundSum >>> FRAC;

   always_comb begin
      clamped = '0;
      if (shifted[ACC_W-1])
         clamped = '0;
      else if (shifted > PIX_MAX)
         clamped = '1;
      else
         clamped = shifted[PIX_W-1:0];
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = (tap_count != 8'd0) ? ACCUM : OUT;
         ACCUM:   if (handshake && lastTap) stateNext = DRAIN;
         DRAIN:   stateNext = OUT;
         OUT:     if (out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         tapsTarget <= '0;
         tapCnt     <= '0;
         prodReg    <= '0;
         prodValid  <= 1'b0;
         acc        <= '0;
         resultReg  <= '0;
         accOutReg  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  tapsTarget <= tap_count;
                  tapCnt     <= '0;
                  prodReg    <= '0;
                  prodValid  <= 1'b0;
                  acc        <= '0;
                  if (tap_count == 8'd0) begin
                     resultReg <= '0;
                     accOutReg <= '0;
                  end
               end
            end
            ACCUM, DRAIN: begin
               acc <= accNext;
               if (handshake) begin
                  prodReg   <= pad ? '0 : prodExt;
                  prodValid <= 1'b1;
                  tapCnt    <= tapCnt + 8'd1;
               end else begin
                  prodValid <= 1'b0;
               end
               // Output registers load from accNext so the drained last product is included.
               if (state == DRAIN) begin
                  resultReg <= clamped;
                  accOutReg <= accNext;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_mac_accum.sv
// Directed self-checking bench for conv_mac_accum.
module tb_conv_mac_accum;

   logic        Clk;
   logic        reset_n;
   logic        start;
   logic [7:0]  tap_count;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  pix;
   logic [15:0] coef;
   logic        pad;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  result;
   logic [31:0] acc_out;

   int passCnt;
   int totalCnt;

   logic [7:0]  tapPix  [32];
   logic [15:0] tapCoef [32];
   logic        tapPad  [32];
   int          tapGap  [32];

   conv_mac_accum #(.PIX_W(8), .COEF_W(16), .FRAC(8), .ACC_W(32)) dut (
      .Clk(Clk), .reset_n(reset_n), .start(start), .tap_count(tap_count),
      .in_valid(in_valid), .in_ready(in_ready), .pix(pix), .coef(coef), .pad(pad),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .acc_out(acc_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic fillUniform(input logic [7:0] p, input logic [15:0] c);
      for (int i = 0; i < 32; i++) begin
         tapPix[i]  = p;
         tapCoef[i] = c;
         tapPad[i]  = 1'b0;
         tapGap[i]  = 0;
      end
   endtask

   task automatic doStart(input logic [7:0] n);
      start     = 1'b1;
      tap_count = n;
      @(posedge Clk); #1;
      start     = 1'b0;
   endtask

   task automatic runWindow(input int n, output bit tmo);
      int waitCnt;
      tmo = 1'b0;
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < tapGap[i]; g++) begin
            in_valid = 1'b0;
            pix      = 8'hAA;
            coef     = 16'h7FFF;
            @(posedge Clk); #1;
         end
         in_valid = 1'b1;
         pix      = tapPix[i];
         coef     = tapCoef[i];
         pad      = tapPad[i];
         waitCnt  = 0;
         while (!in_ready && waitCnt < 20) begin
            @(posedge Clk); #1;
            waitCnt++;
         end
         if (!in_ready) tmo = 1'b1;
         @(posedge Clk); #1;
      end
      in_valid = 1'b0;
      pad      = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; tap_count = '0; in_valid = 1'b0;
      pix = '0; coef = '0; pad = 1'b0; out_ready = 1'b0;
      #23;
      totalCnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passCnt++;
      totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passCnt++;
      totalCnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passCnt++;
      totalCnt++; if (result !== 8'd0) $display("FAIL reset_result: got %0d expected 0", result); else passCnt++;
      totalCnt++; if (acc_out !== 32'd0) $display("FAIL reset_acc_out: got %0d expected 0", acc_out); else passCnt++;
      reset_n = 1'b1;
   endtask

   task automatic test_nominal;
      bit tmo;
      fillUniform(8'd100, 16'h001C);
      doStart(8'd9);
      totalCnt++; if (busy !== 1'b1) $display("FAIL nom_first_start_busy: got %b expected 1", busy); else passCnt++;
      totalCnt++; if (in_ready !== 1'b1) $display("FAIL nom_in_ready: got %b expected 1", in_ready); else passCnt++;
      runWindow(9, tmo);
      totalCnt++; if (tmo !== 1'b0) $display("FAIL nom_tap_timeout: got %b expected 0", tmo); else passCnt++;
      totalCnt++; if (out_valid !== 1'b0) $display("FAIL nom_drain_out_valid: got %b expected 0", out_valid); else passCnt++;
      totalCnt++; if (in_ready !== 1'b0) $display("FAIL nom_drain_in_ready: got %b expected 0", in_ready); else passCnt++;
      @(posedge Clk); #1;
      totalCnt++; if (out_valid !== 1'b1) $display("FAIL nom_out_valid: got %b expected 1", out_valid); else passCnt++;
      totalCnt++; if (acc_out !== 32'd25200) $display("FAIL nom_acc_out: got %0d expected 25200", acc_out); else passCnt++;
      totalCnt++; if (result !== 8'd98) $display("FAIL nom_result: got %0d expected 98", result); else passCnt++;
      out_ready = 1'b1;
      @(posedge Clk); #1;
      out_ready = 1'b0;
      totalCnt++; if (out_valid !== 1'b0) $display("FAIL nom_out_drop: got %b expected 0", out_valid); else passCnt++;
      totalCnt++; if (busy !== 1'b0) $display("FAIL nom_idle_busy: got %b expected 0", busy); else passCnt++;
      totalCnt++; if (result !== 8'd98) $display("FAIL nom_result_hold: got %0d expected 98", result); else passCnt++;
      totalCnt++; if (acc_out !== 32'd25200) $display("FAIL nom_acc_hold: got %0d expected 25200", acc_out); else passCnt++;
   endtask

   task automatic test_pad;
      bit tmo;
      fillUniform(8'd100, 16'h001C);
      tapPad[0] = 1'b1; tapPad[2] = 1'b1; tapPad[6] = 1'b1; tapPad[8] = 1'b1;
      doStart(8'd9);
      runWindow(9, tmo);
      @(posedge Clk); #1;
      totalCnt++; if (tmo !== 1'b0) $display("FAIL pad_tap_timeout: got %b expected 0", tmo); else passCnt++;
      totalCnt++; if (acc_out !== 32'd14000) $display("FAIL pad_acc_out: got %0d expected 14000", acc_out); else passCnt++;
      totalCnt++; if (result !== 8'd55) $display("FAIL pad_result: got %0d expected 55", result); else passCnt++;
      out_ready = 1'b1; @(posedge Clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_clamp;
      bit tmo;
      fillUniform(8'd255, 16'h0400);
      doStart(8'd1);
      runWindow(1, tmo);
      @(posedge Clk); #1;
      totalCnt++; if (out_valid !== 1'b1) $display("FAIL clamp_hi_valid: got %b expected 1", out_valid); else passCnt++;
      totalCnt++; if (acc_out !== 32'd261120) $display("FAIL clamp_hi_acc: got %0d expected 261120", acc_out); else passCnt++;
      totalCnt++; if (result !== 8'd255) $display("FAIL clamp_hi_result: got %0d expected 255", result); else passCnt++;
      out_ready = 1'b1; @(posedge Clk); #1; out_ready = 1'b0;
      fillUniform(8'd50, 16'hFE00);
      doStart(8'd1);
      runWindow(1, tmo);
      @(posedge Clk); #1;
      totalCnt++; if ($signed(acc_out) !== -25600) $display("FAIL clamp_lo_acc: got %0d expected -25600", $signed(acc_out)); else passCnt++;
      totalCnt++; if (result !== 8'd0) $display("FAIL clamp_lo_result: got %0d expected 0", result); else passCnt++;
      out_ready = 1'b1; @(posedge Clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      bit tmo;
      fillUniform(8'd100, 16'h001C);
      doStart(8'd9);
      // A start held through the window and into OUT must have no effect.
      start     = 1'b1;
      tap_count = 8'd3;
      runWindow(9, tmo);
      @(posedge Clk); #1;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) start = 1'b0;
         totalCnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b expected 1", c, out_valid); else passCnt++;
         totalCnt++; if (result !== 8'd98) $display("FAIL bp_result[%0d]: got %0d expected 98", c, result); else passCnt++;
         totalCnt++; if (acc_out !== 32'd25200) $display("FAIL bp_acc[%0d]: got %0d expected 25200", c, acc_out); else passCnt++;
         totalCnt++; if (busy !== 1'b1) $display("FAIL bp_busy[%0d]: got %b expected 1", c, busy); else passCnt++;
         @(posedge Clk); #1;
      end
      out_ready = 1'b1;
      @(posedge Clk); #1;
      out_ready = 1'b0;
      totalCnt++; if (busy !== 1'b0) $display("FAIL bp_idle_busy: got %b expected 0", busy); else passCnt++;
      totalCnt++; if (out_valid !== 1'b0) $display("FAIL bp_idle_valid: got %b expected 0", out_valid); else passCnt++;
   endtask

   task automatic test_reset_mid;
      bit tmo;
      fillUniform(8'd100, 16'h001C);
      doStart(8'd9);
      runWindow(4, tmo);
      #2 reset_n = 1'b0;
      #1;
      totalCnt++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", busy); else passCnt++;
      totalCnt++; if (in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %b expected 0", in_ready); else passCnt++;
      totalCnt++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b expected 0", out_valid); else passCnt++;
      totalCnt++; if (result !== 8'd0) $display("FAIL rmid_result: got %0d expected 0", result); else passCnt++;
      totalCnt++; if (acc_out !== 32'd0) $display("FAIL rmid_acc_out: got %0d expected 0", acc_out); else passCnt++;
      @(posedge Clk); #1;
      reset_n = 1'b1;
      doStart(8'd9);
      runWindow(9, tmo);
      @(posedge Clk); #1;
      totalCnt++; if (acc_out !== 32'd25200) $display("FAIL rmid_new_acc: got %0d expected 25200", acc_out); else passCnt++;
      totalCnt++; if (result !== 8'd98) $display("FAIL rmid_new_result: got %0d expected 98", result); else passCnt++;
      out_ready = 1'b1; @(posedge Clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_zero_taps;
      doStart(8'd0);
      totalCnt++; if (out_valid !== 1'b1) $display("FAIL zero_out_valid: got %b expected 1", out_valid); else passCnt++;
      totalCnt++; if (busy !== 1'b1) $display("FAIL zero_busy: got %b expected 1", busy); else passCnt++;
      totalCnt++; if (result !== 8'd0) $display("FAIL zero_result: got %0d expected 0", result); else passCnt++;
      totalCnt++; if (acc_out !== 32'd0) $display("FAIL zero_acc_out: got %0d expected 0", acc_out); else passCnt++;
      out_ready = 1'b1; @(posedge Clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_gaps;
      bit tmo;
      int sum;
      int c;
      int r;
      int expRes;
      sum = 0;
      for (int i = 0; i < 25; i++) begin
         c          = ((i * 13) % 40) - 12;
         tapPix[i]  = 8'((i * 37 + 11) % 256);
         tapCoef[i] = 16'(c);
         tapPad[i]  = ((i % 7) == 3);
         tapGap[i]  = ((i % 4) == 1) ? (i % 3) + 1 : 0;
         if (!tapPad[i]) sum += int'(tapPix[i]) * c;
      end
      r = (sum + 128) >>> 8;
      expRes = (r < 0) ? 0 : (r > 255) ? 255 : r;
      doStart(8'd25);
      runWindow(25, tmo);
      totalCnt++; if (tmo !== 1'b0) $display("FAIL gaps_tap_timeout: got %b expected 0", tmo); else passCnt++;
      @(posedge Clk); #1;
      totalCnt++; if (out_valid !== 1'b1) $display("FAIL gaps_out_valid: got %b expected 1", out_valid); else passCnt++;
      totalCnt++; if ($signed(acc_out) !== sum) $display("FAIL gaps_acc_out: got %0d expected %0d", $signed(acc_out), sum); else passCnt++;
      totalCnt++; if (int'(result) !== expRes) $display("FAIL gaps_result: got %0d expected %0d", result, expRes); else passCnt++;
      out_ready = 1'b1; @(posedge Clk); #1; out_ready = 1'b0;
   endtask

   initial begin
      passCnt  = 0;
      totalCnt = 0;
      test_reset();
      test_nominal();
      test_pad();
      test_clamp();
      test_backpressure();
      test_reset_mid();
      test_zero_taps();
      test_gaps();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
